// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execution stage behind the ALU opcode decoder.
// ADD/SUB/AND/OR finish in one cycle. SLL/SRA iterate one bit per cycle.
// The result is registered and held in DONE until the consumer takes it.
//
// Handshake: a transfer on either side happens on a rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and out_* stay stable there until out_ready is seen.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_op_sel,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_overflow,
    output logic               out_ne,
    output logic               out_lt,
    output logic               out_illegal,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic               shift_sra;

    logic               accept;
    logic               op_onehot;
    logic               is_shift;
    logic               last_shift;
    logic [WIDTH-1:0]   work_next;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;
    logic               alu_ne;
    logic               alu_lt;

    assign accept     = in_valid & in_ready;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign op_onehot  = (in_op_sel != 6'd0) && ((in_op_sel & (in_op_sel - 6'd1)) == 6'd0);
    assign is_shift   = op_onehot & (in_op_sel[4] | in_op_sel[5]);
    assign last_shift = (cnt == SHAMT_W'(1));
    assign work_next  = shift_sra ? {work[WIDTH-1], work[WIDTH-1:1]}
                                  : {work[WIDTH-2:0], 1'b0};

    assign sum  = in_a + in_b;
    assign diff = in_a + ~in_b + WIDTH'(1);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic: short ops and zero-distance shifts skip SHIFT.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && (in_shamt != '0)) state_next = S_SHIFT;
                    else                              state_next = S_DONE;
                end
            end
            S_SHIFT: if (last_shift) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle ALU result and flags; flags not meaningful for an op stay 0.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_ne     = 1'b0;
        alu_lt     = 1'b0;
        if (op_onehot) begin
            if (in_op_sel[0]) begin
                alu_result = sum;
                alu_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);
            end else if (in_op_sel[1]) begin
                alu_result = diff;
                alu_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (diff[WIDTH-1] != in_a[WIDTH-1]);
                alu_ne     = (diff != '0);
                alu_lt     = diff[WIDTH-1] ^ alu_ovf;
            end else if (in_op_sel[2]) begin
                alu_result = in_a & in_b;
            end else if (in_op_sel[3]) begin
                alu_result = in_a | in_b;
            end
        end
    end

    // Datapath: capture at accept, then iterate the shifter one bit per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work         <= '0;
            cnt          <= '0;
            shift_sra    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_ne       <= 1'b0;
            out_lt       <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            shift_sra <= in_op_sel[5];
            if (is_shift) begin
                // A zero shift amount goes straight to DONE with result = A.
                work         <= in_a;
                cnt          <= in_shamt;
                out_result   <= in_a;
                out_overflow <= 1'b0;
                out_ne       <= 1'b0;
                out_lt       <= 1'b0;
                out_illegal  <= 1'b0;
            end else begin
                out_result   <= alu_result;
                out_overflow <= alu_ovf;
                out_ne       <= alu_ne;
                out_lt       <= alu_lt;
                out_illegal  <= ~op_onehot;
            end
        end else if (state == S_SHIFT) begin
            work <= work_next;
            cnt  <= cnt - SHAMT_W'(1);
            if (last_shift) out_result <= work_next;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed cases followed by random ops, each checked
// against a plain-arithmetic reference model.
module tb_alu_seq_exec;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_op_sel;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_overflow;
    logic          out_ne;
    logic          out_lt;
    logic          out_illegal;
    logic          busy;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected {result, overflow, ne, lt, illegal} per issued op.
    logic [W+3:0] exp_q[$];

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_sel   (in_op_sel),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_shamt    (in_shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_overflow(out_overflow),
        .out_ne      (out_ne),
        .out_lt      (out_lt),
        .out_illegal (out_illegal),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: signed arithmetic on wide integers, native shifts.
    function automatic logic [W+3:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [SW-1:0] sh);
        longint sa, sb, s;
        logic [W-1:0] r;
        logic ovf, ne, lt, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; ovf = 0; ne = 0; lt = 0; ill = 0;
        if ($countones(op) != 1) begin
            ill = 1;
        end else if (op[0]) begin
            s = sa + sb;
            r = W'(s);
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op[1]) begin
            s = sa - sb;
            r = W'(s);
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            ne = (a != b);
            lt = (sa < sb);
        end else if (op[2]) begin
            r = a & b;
        end else if (op[3]) begin
            r = a | b;
        end else if (op[4]) begin
            r = (int'(sh) >= W) ? '0 : (a << sh);
        end else begin
            r = W'($signed(a) >>> sh);
        end
        return {r, ovf, ne, lt, ill};
    endfunction

    function automatic int lat_model(input logic [5:0] op, input logic [SW-1:0] sh);
        if ($countones(op) == 1 && (op[4] || op[5]) && sh != 0) return int'(sh) + 1;
        return 1;
    endfunction

    // Issue one op at a negedge in IDLE, wait for the result, stall, then release.
    task automatic do_op(input string name, input logic [5:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SW-1:0] sh, input int stall);
        logic [W+3:0] e;
        logic [W-1:0] held;
        int lat, want_lat;
        exp_q.push_back(model(op, a, b, sh));
        want_lat = lat_model(op, sh);
        chk({name, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op_sel = op; in_a = a; in_b = b; in_shamt = sh;
        @(negedge clock);
        // Scramble inputs after accept; the stage must ignore them.
        in_valid = 1'b0; in_op_sel = 6'($urandom); in_a = $urandom; in_b = $urandom;
        in_shamt = SW'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            chk({name, ":busy"}, 32'(busy), 32'd1);
            @(negedge clock);
            lat++;
        end
        chk({name, ":latency"}, 32'(lat), 32'(want_lat));
        e = exp_q.pop_front();
        chk({name, ":result"},   out_result,         e[W+3:4]);
        chk({name, ":overflow"}, 32'(out_overflow),  32'(e[3]));
        chk({name, ":ne"},       32'(out_ne),        32'(e[2]));
        chk({name, ":lt"},       32'(out_lt),        32'(e[1]));
        chk({name, ":illegal"},  32'(out_illegal),   32'(e[0]));
        held = out_result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_op_sel = 6'd1 << $urandom_range(0, 3);
            @(negedge clock);
            chk({name, ":stall_valid"},  32'(out_valid), 32'd1);
            chk({name, ":stall_result"}, out_result,     held);
            chk({name, ":stall_ready"},  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({name, ":valid_dropped"}, 32'(out_valid), 32'd0);
        chk({name, ":back_idle"},     32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [5:0] op;
        reset_n = 1'b0; in_valid = 1'b0; in_op_sel = '0; in_a = '0; in_b = '0;
        in_shamt = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_result",    out_result,     32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        do_op("add_ovf", 6'b000001, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        chk("add_ovf_value", 32'(model(6'b000001, 32'h7FFF_FFFF, 32'h1, 5'd0) >> 4), 32'h8000_0000);
        do_op("sub_lt", 6'b000010, 32'd3, 32'd5, 5'd0, 0);
        do_op("sub_eq", 6'b000010, 32'd9, 32'd9, 5'd0, 0);
        do_op("sra4",   6'b100000, 32'h8000_0000, 32'h0, 5'd4, 0);
        do_op("sll0",   6'b010000, 32'h1, 32'h0, 5'd0, 0);
        do_op("and_stall", 6'b000100, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 5);
        do_op("ill_zero", 6'b000000, 32'h1234, 32'h5678, 5'd3, 0);
        do_op("ill_two",  6'b000011, 32'h1234, 32'h5678, 5'd3, 0);
        do_op("sll31",  6'b010000, 32'hFFFF_FFFF, 32'h0, 5'd31, 0);
        do_op("sra31",  6'b100000, 32'h8000_0001, 32'h0, 5'd31, 1);
        do_op("sub_min", 6'b000010, 32'h8000_0000, 32'h1, 5'd0, 0);

        // Reset in the middle of a long shift.
        in_valid = 1'b1; in_op_sel = 6'b010000; in_a = 32'hDEAD_BEEF; in_shamt = 5'd31;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        chk("midshift_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy",     32'(busy),       32'd0);
        chk("midreset_in_ready", 32'(in_ready),   32'd1);
        chk("midreset_valid",    32'(out_valid),  32'd0);
        chk("midreset_result",   out_result,      32'd0);
        chk("midreset_flags",    32'({out_overflow, out_ne, out_lt, out_illegal}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_op("or_after_reset", 6'b001000, 32'h1, 32'h2, 5'd0, 0);

        // Random ops: mostly legal one-hot selects, some illegal patterns.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = 6'd1 << $urandom_range(0, 5);
            do_op("rand", op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  SW'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
